// File: rtl/clock_divider_pkg.sv
// Shared constants, phase encoding and width helper for the clock divider.
package clock_divider_pkg;

  localparam int DEFAULT_CLK_IN_HZ  = 20_000_000;
  localparam int DEFAULT_CLK_OUT_HZ = 1;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clock_divider_div_counter.sv
// Phase counter: counts up from zero and strobes tc_o at the terminal value
// of the current phase, restarting from zero on the same edge.
module div_counter
  #(
    parameter int CNT_W = 1,
    parameter int TC_LO = 0,
    parameter int TC_HI = 0
  )
  (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic phase_i,
    output logic tc_o
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc_o  = phase_i ? (cnt_q == CNT_W'(TC_HI)) : (cnt_q == CNT_W'(TC_LO));
    cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_divider.sv
// Divides clk_in down to a registered square wave clk_out (DIV = CLK_IN_HZ/CLK_OUT_HZ).
// Optional one-cycle tick on each clk_out rise when CLOCK_DIVIDER_TICK_EN is defined.
//
// state | meaning
// PH_LO | clk_out low, counting LO cycles
// PH_HI | clk_out high, counting HI cycles
module clock_divider
  import clock_divider_pkg::*;
  #(
    parameter int CLK_IN_HZ  = DEFAULT_CLK_IN_HZ,
    parameter int CLK_OUT_HZ = DEFAULT_CLK_OUT_HZ
  )
  (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out
`ifdef CLOCK_DIVIDER_TICK_EN
    ,
    output logic tick
`endif
  );

  localparam int DIV   = CLK_IN_HZ / CLK_OUT_HZ;
  localparam int LO    = DIV / 2;
  localparam int HI    = DIV - LO;
  localparam int CNT_W = cnt_width(HI);

  if (DIV < 2) begin : g_div_check
    $error("clock_divider: CLK_OUT_HZ must not exceed CLK_IN_HZ/2");
  end

  phase_e state_q, state_d;
  logic   tc;

  div_counter #(
    .CNT_W (CNT_W),
    .TC_LO ((LO > 0) ? LO - 1 : 0),
    .TC_HI ((HI > 0) ? HI - 1 : 0)
  ) u_div_counter (
    .clk_i   (clk_in),
    .rst_ni  (rst_n),
    .phase_i (state_q == PH_HI),
    .tc_o    (tc)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= PH_LO;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tc) state_d = (state_q == PH_LO) ? PH_HI : PH_LO;
  end

  always_comb begin
    clk_out = (state_q == PH_HI);
  end

`ifdef CLOCK_DIVIDER_TICK_EN
  // Tick lands on the same edge as the clk_out rise.
  logic tick_q, tick_d;

  always_comb begin
    tick_d = tc && (state_q == PH_LO);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: three instances (20/1, 5/1, 2/1) against a cycle-position model.
module tb_clock_divider;

  localparam int NDUT = 3;
  localparam int DIVS [NDUT] = '{20, 5, 2};

  logic            clk_in = 1'b0;
  logic            rst_n  = 1'b0;
  logic [NDUT-1:0] clk_out;
  logic [NDUT-1:0] tick;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    id;
    int    k;
    logic  clk_exp;
    logic  tick_exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk_in = ~clk_in;

`ifdef CLOCK_DIVIDER_TICK_EN
  clock_divider #(.CLK_IN_HZ(20), .CLK_OUT_HZ(1)) u_div20 (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out[0]), .tick(tick[0]));
  clock_divider #(.CLK_IN_HZ(5), .CLK_OUT_HZ(1)) u_div5 (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out[1]), .tick(tick[1]));
  clock_divider #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) u_div2 (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out[2]), .tick(tick[2]));
`else
  clock_divider #(.CLK_IN_HZ(20), .CLK_OUT_HZ(1)) u_div20 (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out[0]));
  clock_divider #(.CLK_IN_HZ(5), .CLK_OUT_HZ(1)) u_div5 (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out[1]));
  clock_divider #(.CLK_IN_HZ(2), .CLK_OUT_HZ(1)) u_div2 (
    .clk_in(clk_in), .rst_n(rst_n), .clk_out(clk_out[2]));
  assign tick = '0;
`endif

  // Expected outputs k edges after reset release: low for the first LO positions of each period.
  task automatic push_expect(input string tag, input int k, input bit in_reset);
    exp_t e;
    for (int id = 0; id < NDUT; id++) begin
      int div, lo, p;
      div = DIVS[id];
      lo  = div / 2;
      p   = k % div;
      e.tag = tag;
      e.id  = id;
      e.k   = k;
      if (in_reset) begin
        e.clk_exp  = 1'b0;
        e.tick_exp = 1'b0;
      end else begin
        e.clk_exp  = (p >= lo);
        e.tick_exp = (p == lo);
      end
      sb.push_back(e);
    end
  endtask

  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (clk_out[e.id] === e.clk_exp)
      else begin
        failures++;
        $error("FAIL %s div%0d edge %0d clk_out observed=%b expected=%b",
               e.tag, DIVS[e.id], e.k, clk_out[e.id], e.clk_exp);
      end
`ifdef CLOCK_DIVIDER_TICK_EN
      checks++;
      assert (tick[e.id] === e.tick_exp)
      else begin
        failures++;
        $error("FAIL %s div%0d edge %0d tick observed=%b expected=%b",
               e.tag, DIVS[e.id], e.k, tick[e.id], e.tick_exp);
      end
`endif
    end
  endtask

  task automatic run_edges(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      push_expect(tag, k, 1'b0);
      @(posedge clk_in);
      #1;
      check_all();
    end
  endtask

  task automatic reset_edges(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push_expect(tag, 0, 1'b1);
      @(posedge clk_in);
      #1;
      check_all();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    reset_edges("reset_hold", 3);

    @(negedge clk_in);
    rst_n = 1'b1;
    run_edges("run_a", 100);

    @(negedge clk_in);
    rst_n = 1'b0;
    reset_edges("reset_again", 2);
    @(negedge clk_in);
    rst_n = 1'b1;
    run_edges("pre_async", 15);

    // 20/1 instance is mid high phase here; drop reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    push_expect("async_reset", 0, 1'b1);
    check_all();
    reset_edges("async_hold", 2);

    @(negedge clk_in);
    rst_n = 1'b1;
    run_edges("post_async", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
